muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: mult/div/madd/msub family, mthi/mtlo,
// with cancel (pipeline flush) and fixed per-class latency.
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } md_op_e;

  localparam logic [7:0] MULT_N = MULT_CYCLES[7:0];
  localparam logic [7:0] DIV_N  = DIV_CYCLES[7:0];

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Datapath works only on latched operands, so in-flight ops ignore new a/b.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic               div_by_zero;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   dvs_safe;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] result;

  assign acc    = {hi_q, lo_q};
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed divide on magnitudes; MIN/-1 wraps naturally to quotient MIN, remainder 0.
  assign div_signed  = (op_q == OP_DIV);
  assign a_neg       = div_signed && a_q[WIDTH-1];
  assign b_neg       = div_signed && b_q[WIDTH-1];
  assign div_by_zero = (b_q == '0);
  assign dvd         = a_neg ? -a_q : a_q;
  assign dvs         = b_neg ? -b_q : b_q;
  assign dvs_safe    = div_by_zero ? WIDTH'(1) : dvs;
  assign quo_u       = dvd / dvs_safe;
  assign rem_u       = dvd % dvs_safe;
  assign quo         = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem         = a_neg ? -rem_u : rem_u;

  always_comb begin
    result = acc;
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
      OP_DIV,
      OP_DIVU:  result = div_by_zero ? acc : {rem, quo};
      default:  result = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (md_op_e'(md_op))
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              op_d    = md_op_e'(md_op);
              a_d     = a;
              b_d     = b;
              cnt_d   = MULT_N;
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = md_op_e'(md_op);
              a_d     = a;
              b_d     = b;
              cnt_d   = DIV_N;
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Cancel beats completion on the same edge: the result is dropped.
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'd1) begin
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
          state_d      = S_IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
